lbist_misr: RTL and testbench
=============================

Name: lbist_misr

Overview:
- Multiple-input signature register: the downstream consumer stage of the LBIST controller's MISR request channel.
- Accepts a hash-count request, then compresses that many circuit-under-test (CUT) output words into a signature.
- Returns the signature to the controller on a val/rdy response channel.
- One instance per CUT.

Parameters:
- CUT_OUTPUT_BITS, 32, width of one CUT output word.
- SIGNATURE_BITS, 32, width of the signature register.
- MAX_OUTPUTS_TO_HASH, 32, upper bound on words hashed per request.
- MISR_MSG_BITS, $clog2(MAX_OUTPUTS_TO_HASH), request count width minus one.
- TAP_MASK, 32'h80200003, feedback taps; bit i set means sig[i] feeds the parity term. Width is SIGNATURE_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_val  in  1  hash request valid.
- req_rdy  out  1  hash request ready.
- req_msg  in  MISR_MSG_BITS+1  number of CUT words to hash.
- cut_out_val  in  1  CUT output word valid.
- cut_out_rdy  out  1  CUT output word ready.
- cut_out_msg  in  CUT_OUTPUT_BITS  CUT output word.
- resp_val  out  1  signature valid.
- resp_rdy  in  1  signature ready.
- resp_msg  out  SIGNATURE_BITS  signature.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Registered state: state, sig, count_target, count.
  - On reset: state=IDLE, sig=0, count_target=0, count=0.
  - req_rdy, cut_out_rdy and resp_val are 0 in any cycle where reset=1.
- Outputs are Moore, decoded from state:
  - IDLE: req_rdy=1, cut_out_rdy=0, resp_val=0.
  - HASH: req_rdy=0, cut_out_rdy=1, resp_val=0.
  - DONE: req_rdy=0, cut_out_rdy=0, resp_val=1.
- resp_msg = sig at all times. It is 0 after reset.
- A handshake means val && rdy in the same cycle. There is no combinational path from any val input to any rdy output.
- IDLE, on req handshake:
  - count_target = min(req_msg, MAX_OUTPUTS_TO_HASH); sig=0; count=0.
  - Next state is HASH, or DONE if the clamped count is 0 (signature then stays 0).
- HASH, on cut_out handshake:
  - sig_next = {sig[SIGNATURE_BITS-2:0], ^(sig & TAP_MASK)} ^ fold(cut_out_msg).
  - count increments.
  - If count == count_target-1 before the increment, next state is DONE.
  - With no handshake, sig and count hold.
- fold(x):
  - If CUT_OUTPUT_BITS <= SIGNATURE_BITS, x is zero-extended.
  - Otherwise, x is split into SIGNATURE_BITS-wide chunks from the LSB (the top chunk zero-padded) and the chunks are XORed together.
- DONE, on resp handshake: next state is IDLE. sig holds until the next accepted request.
  - resp_val and resp_msg are stable while resp_rdy=0.
- Latency:
  - The first cut_out word can be accepted the cycle after the req handshake.
  - resp_val rises the cycle after the final word is accepted, or the cycle after the req handshake for count 0.
  - Back-to-back: a new request can be accepted the cycle after the resp handshake.
- req_val held high outside IDLE is ignored (the controller keeps req_val asserted through its START phase). Only one request is accepted per pass.
- Reset mid-HASH or mid-DONE: the partial signature is discarded and the block returns to the IDLE/zero state the next cycle.
- count width is MISR_MSG_BITS+1, so MAX_OUTPUTS_TO_HASH is representable without wrap.

Test Plan:
- Single word: req_msg=1, then cut_out_msg=0x00000005 -> resp_val rises one cycle after accept, resp_msg=0x00000005.
- Two words: req_msg=2, words 0x5 then 0x0 -> resp_msg=0x0000000B (shift to 0xA, parity of 0x5&TAP_MASK = 1).
- MSB wrap: req_msg=2, words 0x80000000 then 0x0 -> resp_msg=0x00000001.
- Zero count / clamp:
  - req_msg=0 -> DONE the next cycle, resp_msg=0, cut_out_rdy never asserted.
  - req_msg=33 with MAX=32 -> exactly 32 words consumed.
- Backpressure and stalls:
  - resp_rdy held 0 for 5 cycles -> resp_val and resp_msg stable throughout.
  - cut_out_val gaps in HASH -> sig and count unchanged during the gaps.
  - req_val high in HASH/DONE -> no second accept.
- Reset mid-HASH after 3 of 8 words -> next cycle is IDLE, req_rdy=1, resp_msg=0; a fresh 1-word request with 0x5 yields 0x5.

Source files
------------

// File: rtl/lbist_misr_if.sv
// lbist_misr_if: bundles the three channels of the MISR block.
//   req_*     : hash-count request from the LBIST controller.
//   cut_out_* : circuit-under-test output words to be compressed.
//   resp_*    : signature returned to the controller.
// Modports:
//   master : the controller/CUT side (drives val and msg on req and cut_out,
//            drives rdy on resp).
//   slave  : the MISR side (lbist_misr).
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clock edge where val && rdy are both 1. A producer holding val high must
// keep msg stable until the transfer happens. rdy never depends
// combinationally on val.
interface lbist_misr_if #(
    parameter int CUT_OUTPUT_BITS = 32,
    parameter int SIGNATURE_BITS  = 32,
    parameter int MISR_MSG_BITS   = 5
);
    logic                       req_val;
    logic                       req_rdy;
    logic [MISR_MSG_BITS:0]     req_msg;

    logic                       cut_out_val;
    logic                       cut_out_rdy;
    logic [CUT_OUTPUT_BITS-1:0] cut_out_msg;

    logic                       resp_val;
    logic                       resp_rdy;
    logic [SIGNATURE_BITS-1:0]  resp_msg;

    modport master (
        output req_val, req_msg, cut_out_val, cut_out_msg, resp_rdy,
        input  req_rdy, cut_out_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, cut_out_val, cut_out_msg, resp_rdy,
        output req_rdy, cut_out_rdy, resp_val, resp_msg
    );
endinterface

// File: rtl/lbist_misr.sv
// lbist_misr: multiple-input signature register for one circuit under test.
// Accepts a hash-count request, compresses that many CUT output words into
// a signature with an LFSR-style shift/feedback, then returns the signature.
// Ports:
//   clk       : clock.
//   reset     : synchronous, active-high reset.
//   bus       : lbist_misr_if.slave carrying the req, cut_out and resp
//               channels.
//   dbg_state : current FSM state (0=IDLE, 1=HASH, 2=DONE).
module lbist_misr #(
    parameter int                      CUT_OUTPUT_BITS     = 32,
    parameter int                      SIGNATURE_BITS      = 32,
    parameter int                      MAX_OUTPUTS_TO_HASH = 32,
    parameter int                      MISR_MSG_BITS       = $clog2(MAX_OUTPUTS_TO_HASH),
    parameter logic [SIGNATURE_BITS-1:0] TAP_MASK          = 32'h80200003
) (
    input  logic       clk,
    input  logic       reset,
    lbist_misr_if.slave bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW = MISR_MSG_BITS + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTPUTS_TO_HASH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    // Number of signature-wide chunks a CUT word splits into (at least 1).
    localparam int NCHUNK = (CUT_OUTPUT_BITS + SIGNATURE_BITS - 1) / SIGNATURE_BITS;

    state_e                    state_q, state_d;
    logic [SIGNATURE_BITS-1:0] sig_q, sig_d;
    logic [CW-1:0]             count_target_q, count_target_d;
    logic [CW-1:0]             count_q, count_d;

    logic                      req_hs;
    logic                      cut_hs;
    logic                      resp_hs;
    logic [CW-1:0]             clamped_req;

    // Narrow words are zero-extended; wide words are cut into signature-wide
    // chunks from the LSB (top chunk zero-padded) and XORed together. With a
    // single chunk the loop reduces to plain zero-extension.
    function automatic logic [SIGNATURE_BITS-1:0] fold(input logic [CUT_OUTPUT_BITS-1:0] x);
        logic [NCHUNK*SIGNATURE_BITS-1:0] padded;
        logic [SIGNATURE_BITS-1:0]        acc;
        padded                      = '0;
        padded[CUT_OUTPUT_BITS-1:0] = x;
        acc                         = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            acc = acc ^ padded[i*SIGNATURE_BITS +: SIGNATURE_BITS];
        end
        return acc;
    endfunction

    // Moore outputs; reset forces every ready/valid low in its own cycle.
    always_comb begin
        bus.req_rdy     = !reset && (state_q == IDLE);
        bus.cut_out_rdy = !reset && (state_q == HASH);
        bus.resp_val    = !reset && (state_q == DONE);
        bus.resp_msg    = sig_q;
        dbg_state       = state_q;
    end

    assign req_hs      = bus.req_val && bus.req_rdy;
    assign cut_hs      = bus.cut_out_val && bus.cut_out_rdy;
    assign resp_hs     = bus.resp_val && bus.resp_rdy;
    assign clamped_req = (bus.req_msg > MAX_CNT) ? MAX_CNT : bus.req_msg;

    always_comb begin
        state_d        = state_q;
        sig_d          = sig_q;
        count_target_d = count_target_q;
        count_d        = count_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    count_target_d = clamped_req;
                    sig_d          = '0;
                    count_d        = '0;
                    // A zero-length request skips hashing; signature stays 0.
                    state_d        = (clamped_req == '0) ? DONE : HASH;
                end
            end
            HASH: begin
                if (cut_hs) begin
                    sig_d   = {sig_q[SIGNATURE_BITS-2:0], ^(sig_q & TAP_MASK)}
                              ^ fold(bus.cut_out_msg);
                    count_d = count_q + ONE;
                    if (count_q == count_target_q - ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sig_q          <= '0;
            count_target_q <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            sig_q          <= sig_d;
            count_target_q <= count_target_d;
            count_q        <= count_d;
        end
    end

endmodule

// File: tb/tb_lbist_misr.sv
// tb_lbist_misr: drives lbist_misr through hand-computed vectors, random
// passes, clamp, backpressure, stalls and a mid-hash reset; expected
// signatures go into exp_q when a pass is launched and are popped at the
// resp handshake.
module tb_lbist_misr;

    localparam int CB  = 32;
    localparam int SB  = 32;
    localparam int MAX = 32;
    localparam int MB  = $clog2(MAX);
    localparam logic [SB-1:0] TAP = 32'h80200003;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    lbist_misr_if #(.CUT_OUTPUT_BITS(CB), .SIGNATURE_BITS(SB), .MISR_MSG_BITS(MB)) bus ();

    lbist_misr #(
        .CUT_OUTPUT_BITS(CB), .SIGNATURE_BITS(SB),
        .MAX_OUTPUTS_TO_HASH(MAX), .MISR_MSG_BITS(MB), .TAP_MASK(TAP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    logic [SB-1:0] exp_q[$];
    logic [CB-1:0] stim_q[$];

    typedef struct {
        int               req_n;
        int               nw;
        logic [3:0][31:0] w;      // w[0] is the first word sent
        logic [31:0]      exp_sig;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [SB-1:0] model_step(input logic [SB-1:0] sig, input logic [CB-1:0] w);
        return {sig[SB-2:0], ^(sig & TAP)} ^ w;
    endfunction

    // One full pass: request, feed min(req_n, MAX) words from stim_q,
    // optional resp backpressure, resp handshake with scoreboard pop.
    task automatic run_pass(input int req_n, input int gap_max, input int resp_wait,
                            input bit hold_req, input bit have_exp, input logic [SB-1:0] given_exp);
        int            n_words;
        int            t;
        int            gaps;
        logic [SB-1:0] sig_run;
        logic [SB-1:0] e;
        n_words = (req_n > MAX) ? MAX : req_n;
        if (have_exp) begin
            e = given_exp;
        end else begin
            e = '0;
            for (int i = 0; i < n_words; i++) e = model_step(e, stim_q[i]);
        end
        exp_q.push_back(e);
        sig_run = '0;

        @(negedge clk);
        bus.req_val = 1'b1;
        bus.req_msg = req_n[MB:0];
        t = 0;
        while (!bus.req_rdy && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check("req_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (!hold_req) bus.req_val = 1'b0;
        check("req_rdy_after_accept", 32'(bus.req_rdy), 32'd0);

        for (int k = 0; k < n_words; k++) begin
            gaps = $urandom_range(0, gap_max);
            repeat (gaps) begin
                check("gap_sig_hold", bus.resp_msg, sig_run);
                check("req_rdy_in_hash", 32'(bus.req_rdy), 32'd0);
                @(negedge clk);
            end
            bus.cut_out_val = 1'b1;
            bus.cut_out_msg = stim_q.pop_front();
            t = 0;
            while (!bus.cut_out_rdy && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) check("cut_accept_timeout", 32'd0, 32'd1);
            sig_run = model_step(sig_run, bus.cut_out_msg);
            @(negedge clk);
            bus.cut_out_val = 1'b0;
        end

        // Clamped request: keep offering an extra word, it must not be taken.
        if (req_n > MAX) begin
            bus.cut_out_val = 1'b1;
            bus.cut_out_msg = $urandom();
        end
        check("resp_val_latency", 32'(bus.resp_val), 32'd1);
        check("cut_rdy_in_done", 32'(bus.cut_out_rdy), 32'd0);
        if (hold_req) check("req_ignored_in_done", 32'(bus.req_rdy), 32'd0);

        repeat (resp_wait) begin
            @(negedge clk);
            check("resp_val_stall", 32'(bus.resp_val), 32'd1);
            check("resp_msg_stall", bus.resp_msg, exp_q[0]);
        end
        bus.resp_rdy = 1'b1;
        bus.req_val  = 1'b0;
        e = exp_q.pop_front();
        check("resp_sig", bus.resp_msg, e);
        @(negedge clk);
        bus.resp_rdy    = 1'b0;
        bus.cut_out_val = 1'b0;
        check("req_rdy_after_resp", 32'(bus.req_rdy), 32'd1);
        check("resp_val_drop", 32'(bus.resp_val), 32'd0);
    endtask

    initial begin
        int t;
        vecs[0] = '{req_n: 1, nw: 1, w: {32'h0, 32'h0, 32'h0, 32'h5},        exp_sig: 32'h0000_0005};
        vecs[1] = '{req_n: 2, nw: 2, w: {32'h0, 32'h0, 32'h0, 32'h5},        exp_sig: 32'h0000_000B};
        vecs[2] = '{req_n: 2, nw: 2, w: {32'h0, 32'h0, 32'h0, 32'h8000_0000}, exp_sig: 32'h0000_0001};
        vecs[3] = '{req_n: 0, nw: 0, w: {32'h0, 32'h0, 32'h0, 32'h0},        exp_sig: 32'h0000_0000};
        vecs[4] = '{req_n: 3, nw: 3, w: {32'h0, 32'h1, 32'h1, 32'h1},        exp_sig: 32'h0000_0004};
        vecs[5] = '{req_n: 2, nw: 2, w: {32'h0, 32'h0, 32'h0, 32'h0020_0000}, exp_sig: 32'h0040_0001};

        // Clock/reset.
        reset           = 1'b1;
        bus.req_val     = 1'b0;
        bus.req_msg     = '0;
        bus.cut_out_val = 1'b0;
        bus.cut_out_msg = '0;
        bus.resp_rdy    = 1'b0;
        repeat (2) @(negedge clk);
        check("req_rdy_in_reset", 32'(bus.req_rdy), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("reset_cut_rdy", 32'(bus.cut_out_rdy), 32'd0);
        check("reset_resp_val", 32'(bus.resp_val), 32'd0);
        check("reset_resp_msg", bus.resp_msg, 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        // Hand-computed vectors.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].nw; i++) stim_q.push_back(vecs[v].w[i]);
            run_pass(vecs[v].req_n, 0, 0, 1'b0, 1'b1, vecs[v].exp_sig);
        end

        // Resp backpressure for 5 cycles.
        stim_q.push_back(32'h5);
        stim_q.push_back(32'h0);
        run_pass(2, 0, 5, 1'b0, 1'b1, 32'h0000_000B);

        // Clamp: 33 requested, exactly 32 consumed.
        for (int i = 0; i < MAX; i++) stim_q.push_back($urandom());
        run_pass(MAX + 1, 1, 1, 1'b0, 1'b0, '0);

        // Random passes with gaps, stalls and req_val held high.
        for (int p = 0; p < 8; p++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) stim_q.push_back($urandom());
            run_pass(n, 3, $urandom_range(0, 3), 1'(p % 2), 1'b0, '0);
        end

        // Reset after 3 of 8 words.
        @(negedge clk);
        bus.req_val = 1'b1;
        bus.req_msg = 6'd8;
        t = 0;
        while (!bus.req_rdy && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check("rst_seq_req_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.req_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.cut_out_val = 1'b1;
            bus.cut_out_msg = $urandom() | 32'h1;
            t = 0;
            while (!bus.cut_out_rdy && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) check("rst_seq_cut_timeout", 32'd0, 32'd1);
            @(negedge clk);
            bus.cut_out_val = 1'b0;
        end
        check("mid_hash_state", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        #1;
        check("cut_rdy_gated_in_reset", 32'(bus.cut_out_rdy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_state", 32'(dbg_state), 32'd0);
        check("post_rst_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("post_rst_resp_msg", bus.resp_msg, 32'd0);
        stim_q.push_back(32'h5);
        run_pass(1, 0, 0, 1'b0, 1'b1, 32'h0000_0005);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
